// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUS_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Writeback source selects as seen in the EX stage
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam int STALL_CNT_W = 16;
    localparam int WAIT_CNT_W  = 4;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare
// Ports:
//   id_rf_rr1/id_rf_rr2   ID source register numbers
//   id_rr1_used/rr2_used  source actually read by the ID instruction
//   ex_rf_wr/ex_rf_we     EX destination register and write enable
//   ex_wd_sel             EX writeback select (load when WD_MEM)
//   load_use              ID needs a value that the EX load has not produced yet
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rf_rr1,
    input  logic [4:0] id_rf_rr2,
    input  logic       id_rr1_used,
    input  logic       id_rr2_used,
    input  logic [4:0] ex_rf_wr,
    input  logic       ex_rf_we,
    input  logic [1:0] ex_wd_sel,
    output logic       load_use
);

    logic ex_is_load;
    logic rr1_hit;
    logic rr2_hit;

    // x0 is hardwired to zero, so a load targeting it never produces a value to wait for
    assign ex_is_load = ex_rf_we && (ex_wd_sel == WD_MEM) && (ex_rf_wr != 5'd0);
    assign rr1_hit    = id_rr1_used && (id_rf_rr1 == ex_rf_wr);
    assign rr2_hit    = id_rr2_used && (id_rf_rr2 == ex_rf_wr);
    assign load_use   = ex_is_load && (rr1_hit || rr2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with bus-wait timeout
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_rf_rr1/2, id_rr1/2_used     ID-stage source operands
//   ex_rf_wr, ex_rf_we, ex_wd_sel  EX-stage destination info
//   ex_branch_taken                EX resolved a taken branch/jump
//   mem_bus_req, bus_ack           MEM-stage bus handshake
//   pc_stall .. ex_mem_stall       hold PC / pipeline registers
//   if_id_flush, id_ex_flush       inject bubbles
//   mem_wb_bubble                  MEM/WB captures a bubble
//   bus_err                        sticky bus timeout flag
//   stall_cnt                      saturating count of pc_stall cycles
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rf_rr1,
    input  logic [4:0]             id_rf_rr2,
    input  logic                   id_rr1_used,
    input  logic                   id_rr2_used,
    input  logic [4:0]             ex_rf_wr,
    input  logic                   ex_rf_we,
    input  logic [1:0]             ex_wd_sel,
    input  logic                   ex_branch_taken,
    input  logic                   mem_bus_req,
    input  logic                   bus_ack,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   id_ex_stall,
    output logic                   ex_mem_stall,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   mem_wb_bubble,
    output logic                   bus_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(BUS_TIMEOUT);

    state_t                  state;
    state_t                  state_nxt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt_nxt;
    logic                    err_set;
    logic                    bus_hold;
    logic                    load_use;

    assign bus_hold = mem_bus_req && !bus_ack;

    hazard_detect u_hazard_detect (
        .id_rf_rr1   (id_rf_rr1),
        .id_rf_rr2   (id_rf_rr2),
        .id_rr1_used (id_rr1_used),
        .id_rr2_used (id_rr2_used),
        .ex_rf_wr    (ex_rf_wr),
        .ex_rf_we    (ex_rf_we),
        .ex_wd_sel   (ex_wd_sel),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) begin
                bus_err <= 1'b1;
            end
            if (pc_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        err_set       = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state)
            RUN: begin
                if (bus_hold) begin
                    state_nxt    = BUS_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            BUS_WAIT: begin
                // A dropped request is treated like an ack: nothing left to wait for
                if (!bus_hold) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt + 1'b1 == TIMEOUT_LIM) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        // Reset is asynchronous, so the decodes are gated directly rather than
        // waiting for the state register to clear.
        if (rst) begin
            pc_stall = 1'b0;
        end else if (state == ERR || bus_hold) begin
            // EX is frozen, so branch and load-use wait until the bus releases
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // The wrong-path instruction in ID is discarded anyway, so no load-use stall
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int BT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rf_rr1 = '0;
    logic [4:0]  id_rf_rr2 = '0;
    logic        id_rr1_used = 1'b0;
    logic        id_rr2_used = 1'b0;
    logic [4:0]  ex_rf_wr = '0;
    logic        ex_rf_we = 1'b0;
    logic [1:0]  ex_wd_sel = '0;
    logic        ex_branch_taken = 1'b0;
    logic        mem_bus_req = 1'b0;
    logic        bus_ack = 1'b0;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, bus_err;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: error flag, length of the current run of held cycles, stall count
    bit m_err      = 1'b0;
    int m_hold_run = 0;
    int m_cnt      = 0;

    pipe_hazard_ctrl #(.BUS_TIMEOUT(BT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rf_rr1       (id_rf_rr1),
        .id_rf_rr2       (id_rf_rr2),
        .id_rr1_used     (id_rr1_used),
        .id_rr2_used     (id_rr2_used),
        .ex_rf_wr        (ex_rf_wr),
        .ex_rf_we        (ex_rf_we),
        .ex_wd_sel       (ex_wd_sel),
        .ex_branch_taken (ex_branch_taken),
        .mem_bus_req     (mem_bus_req),
        .bus_ack         (bus_ack),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .bus_err         (bus_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {pc, if_id, id_ex, ex_mem stall, if_id flush, id_ex flush, bubble}
    function automatic logic [6:0] model_ctrl();
        bit held;
        bit lu;
        held = mem_bus_req && !bus_ack;
        lu = ex_rf_we && ex_wd_sel == 2'b01 && ex_rf_wr != 5'd0 &&
             ((id_rr1_used && id_rf_rr1 == ex_rf_wr) || (id_rr2_used && id_rf_rr2 == ex_rf_wr));
        if (rst)                 return 7'b0000000;
        if (m_err || held)       return 7'b1111001;
        if (ex_branch_taken)     return 7'b0000110;
        if (lu)                  return 7'b1100010;
        return 7'b0000000;
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_err      = 1'b0;
            m_hold_run = 0;
            m_cnt      = 0;
        end
        check("ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
        check("bus_err", 32'(bus_err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    // Error after BT cycles spent waiting, i.e. BT+1 consecutive held cycles counting the request cycle
    always @(posedge clk) begin
        if (!rst) begin
            if (model_ctrl() & 7'b1000000) begin
                m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            end
            if (!m_err) begin
                if (mem_bus_req && !bus_ack) begin
                    m_hold_run++;
                    if (m_hold_run == BT + 1) m_err = 1'b1;
                end else begin
                    m_hold_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        id_rf_rr1 = '0; id_rf_rr2 = '0; id_rr1_used = 0; id_rr2_used = 0;
        ex_rf_wr = '0; ex_rf_we = 0; ex_wd_sel = '0; ex_branch_taken = 0;
        mem_bus_req = 0; bus_ack = 0;
    endtask

    task automatic load_x5_rr2();
        ex_rf_we = 1; ex_wd_sel = 2'b01; ex_rf_wr = 5'd5;
        id_rf_rr2 = 5'd5; id_rr2_used = 1; id_rf_rr1 = 5'd7; id_rr1_used = 1;
    endtask

    task automatic rst_pulse();
        rst = 1; idle();
        tick();
        rst = 0;
    endtask

    initial begin
        idle();
        tick(); tick();
        settle();
        check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst = 0;

        // load-use via rr2
        load_x5_rr2();
        settle();
        check("lu_ctrl", 32'(dut_ctrl()), 32'b1100010);
        tick(); idle(); settle();
        check("lu_once", 32'(pc_stall), 32'd0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);

        // x0 destination and unused source do not stall
        tick(); load_x5_rr2(); ex_rf_wr = 5'd0; id_rf_rr2 = 5'd0; settle();
        check("x0_no_stall", 32'(dut_ctrl()), 32'd0);
        tick(); load_x5_rr2(); id_rr2_used = 0; settle();
        check("unused_no_stall", 32'(dut_ctrl()), 32'd0);
        tick(); idle(); settle();
        check("no_stall_cnt", 32'(stall_cnt), 32'd1);

        // branch beats load-use
        tick(); load_x5_rr2(); ex_branch_taken = 1; settle();
        check("br_lu_ctrl", 32'(dut_ctrl()), 32'b0000110);
        tick(); idle();

        // bus wait of three cycles with a deferred branch
        rst_pulse();
        for (int i = 0; i < 3; i++) begin
            mem_bus_req = 1; bus_ack = 0; ex_branch_taken = 1;
            settle();
            check("hold_ctrl", 32'(dut_ctrl()), 32'b1111001);
            tick();
        end
        bus_ack = 1; settle();
        check("ack_ctrl", 32'(dut_ctrl()), 32'b0000110);
        tick(); idle(); settle();
        check("hold_cnt", 32'(stall_cnt), 32'd3);
        check("hold_no_err", 32'(bus_err), 32'd0);

        // timeout into ERR
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            mem_bus_req = 1; bus_ack = 0;
            settle();
            check("pre_err", 32'(bus_err), 32'd0);
            tick();
        end
        settle();
        check("err_set", 32'(bus_err), 32'd1);
        tick(); mem_bus_req = 0; ex_branch_taken = 1; settle();
        check("err_ctrl", 32'(dut_ctrl()), 32'b1111001);
        tick(); tick(); settle();
        check("err_sticky", 32'(bus_err), 32'd1);
        tick(); rst = 1; idle(); settle();
        check("err_rst_flag", 32'(bus_err), 32'd0);
        check("err_rst_cnt", 32'(stall_cnt), 32'd0);
        check("err_rst_ctrl", 32'(dut_ctrl()), 32'd0);
        tick(); rst = 0; settle();
        check("after_rst_ctrl", 32'(dut_ctrl()), 32'd0);

        // saturation
        tick();
        force dut.stall_cnt = 16'hFFFE;
        m_cnt = 32'h0000FFFE;
        tick();
        release dut.stall_cnt;
        mem_bus_req = 1; bus_ack = 0;
        tick(); settle();
        check("sat_step", 32'(stall_cnt), 32'h0000FFFF);
        for (int i = 0; i < 4; i++) tick();
        idle(); settle();
        check("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        tick();
        rst_pulse();

        // randomized traffic; second half pushes the bus toward timeouts
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            id_rf_rr1       = 5'($urandom_range(0, 3));
            id_rf_rr2       = 5'($urandom_range(0, 3));
            id_rr1_used     = 1'($urandom_range(0, 1));
            id_rr2_used     = 1'($urandom_range(0, 1));
            ex_rf_wr        = 5'($urandom_range(0, 3));
            ex_rf_we        = 1'($urandom_range(0, 1));
            ex_wd_sel       = 2'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if (i < 2000) begin
                mem_bus_req = ($urandom_range(0, 3) == 0);
                bus_ack     = 1'($urandom_range(0, 1));
            end else begin
                mem_bus_req = ($urandom_range(0, 3) != 0);
                bus_ack     = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        rst = 0; idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
